// File: rtl/cond_unit_if.sv
// Condition unit bus: flag-register traffic, instruction issue and IT
// controls in, condition results and ITSTATE out.
// Package cond_unit_pkg carries the NZCV flag type shared with the ALU.

package cond_unit_pkg;
    // NZCV ordering: n is bit 3, v is bit 0.
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;
endpackage

// Handshake: there is no back-pressure. instr_valid marks the single
// instruction issuing this cycle and exec_en says, in the same cycle,
// whether it executes. it_start marks that this issue slot is an IT.
// Registered results (flags_q, itstate, it_err) change only on posedge clk.
interface cond_if;
    import cond_unit_pkg::*;

    alu_flags_t  flags_in;
    logic        flags_we;
    logic        instr_valid;
    logic        it_start;
    logic [3:0]  it_firstcond;
    logic [3:0]  it_mask;
    logic [3:0]  cond_in;
    logic        cond_pass;
    logic        exec_en;
    alu_flags_t  flags_q;
    logic [7:0]  itstate;
    logic        it_active;
    logic        it_err;

    modport master (
        output flags_in, flags_we, instr_valid, it_start,
               it_firstcond, it_mask, cond_in,
        input  cond_pass, exec_en, flags_q, itstate, it_active, it_err
    );

    modport slave (
        input  flags_in, flags_we, instr_valid, it_start,
               it_firstcond, it_mask, cond_in,
        output cond_pass, exec_en, flags_q, itstate, it_active, it_err
    );
endinterface

// File: rtl/cond_unit.sv
// Condition unit: APSR NZCV flags register, condition-code evaluation and
// the ARMv7-M IT block state machine (ITSTATE[7:0]).
// Configuration macro: COND_UNIT_IT_EN. When it is defined the full IT logic is
// built; when it is undefined ITSTATE is tied to zero, it_start is ignored and
// every valid instruction executes.

module cond_unit
    import cond_unit_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    cond_if.slave  bus
);

    // Condition table; conditions are evaluated on the registered flags only.
    function automatic logic cond_eval(input logic [3:0] c, input alu_flags_t f);
        logic r;
        case (c[3:1])
            3'b000:  r = f.z;
            3'b001:  r = f.c;
            3'b010:  r = f.n;
            3'b011:  r = f.v;
            3'b100:  r = f.c & ~f.z;
            3'b101:  r = (f.n == f.v);
            3'b110:  r = ~f.z & (f.n == f.v);
            default: r = 1'b1;
        endcase
        // Odd codes invert the even base, except 1111 which is also "always".
        if (c[0] && (c[3:1] != 3'b111)) begin
            r = ~r;
        end
        return r;
    endfunction

    alu_flags_t flags_r;
    logic       exec_en;

    assign bus.cond_pass = cond_eval(bus.cond_in, flags_r);
    assign bus.flags_q   = flags_r;
    assign bus.exec_en   = exec_en;

`ifdef COND_UNIT_IT_EN

    logic [7:0] itstate_r;
    logic       it_err_r;
    logic       it_active;
    logic       it_legal;

    assign it_active = (itstate_r[3:0] != 4'b0000);
    // A nested IT, an empty mask or firstcond 1111 are rejected.
    assign it_legal  = !it_active && (bus.it_mask != 4'b0000) &&
                       (bus.it_firstcond != 4'b1111);

    // The IT instruction itself never executes; inside a block the
    // instruction is predicated by the current condition in ITSTATE[7:4].
    always_comb begin
        exec_en = 1'b0;
        if (bus.instr_valid && !bus.it_start) begin
            exec_en = it_active ? cond_eval(itstate_r[7:4], flags_r) : 1'b1;
        end
    end

    // Flags register, ITSTATE load/advance and the one-cycle error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_r   <= '0;
            itstate_r <= 8'h00;
            it_err_r  <= 1'b0;
        end else begin
            it_err_r <= 1'b0;
            if (bus.flags_we && exec_en) begin
                flags_r <= bus.flags_in;
            end
            if (bus.it_start) begin
                if (it_legal) begin
                    itstate_r <= {bus.it_firstcond, bus.it_mask};
                end else begin
                    it_err_r <= 1'b1;
                end
            end else if (bus.instr_valid && it_active) begin
                // Advance even when the condition fails; the mask shift also
                // moves the next condition's low bit into ITSTATE[4].
                if (itstate_r[2:0] == 3'b000) begin
                    itstate_r <= 8'h00;
                end else begin
                    itstate_r <= {itstate_r[7:5], itstate_r[3:0], 1'b0};
                end
            end
        end
    end

    assign bus.itstate   = itstate_r;
    assign bus.it_active = it_active;
    assign bus.it_err    = it_err_r;

`else

    // IT controls are not used in this build.
    logic unused_it;
    assign unused_it = ^{bus.it_start, bus.it_firstcond, bus.it_mask};

    // Without IT support every issued instruction executes.
    always_comb begin
        exec_en = bus.instr_valid;
    end

    // Flags register only; no IT state exists.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_r <= '0;
        end else if (bus.flags_we && exec_en) begin
            flags_r <= bus.flags_in;
        end
    end

    assign bus.itstate   = 8'h00;
    assign bus.it_active = 1'b0;
    assign bus.it_err    = 1'b0;

`endif

endmodule

// File: tb/tb_cond_unit.sv
// Testbench for cond_unit: condition table vectors plus hand-written IT
// sequences. Follows the COND_UNIT_IT_EN setting of the build.

module tb_cond_unit;
    import cond_unit_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cond_if bus ();

    cond_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] f;
        logic [3:0] c;
        logic       exp;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.flags_in     = '0;
        bus.flags_we     = 1'b0;
        bus.instr_valid  = 1'b0;
        bus.it_start     = 1'b0;
        bus.it_firstcond = 4'h0;
        bus.it_mask      = 4'h0;
        bus.cond_in      = 4'h0;
    endtask

    task automatic load_flags(input logic [3:0] f);
        bus.flags_in    = f;
        bus.flags_we    = 1'b1;
        bus.instr_valid = 1'b1;
        tick();
        bus.flags_we    = 1'b0;
        bus.instr_valid = 1'b0;
    endtask

    task automatic issue_it(input logic [3:0] fc, input logic [3:0] mask);
        bus.it_start     = 1'b1;
        bus.instr_valid  = 1'b1;
        bus.it_firstcond = fc;
        bus.it_mask      = mask;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // {flags NZCV, cond, expected cond_pass}
        vecs[0]  = '{4'b0100, 4'b0000, 1'b1};
        vecs[1]  = '{4'b0100, 4'b0001, 1'b0};
        vecs[2]  = '{4'b1001, 4'b1010, 1'b1};
        vecs[3]  = '{4'b1001, 4'b1100, 1'b1};
        vecs[4]  = '{4'b1001, 4'b1101, 1'b0};
        vecs[5]  = '{4'b0010, 4'b0010, 1'b1};
        vecs[6]  = '{4'b0010, 4'b0011, 1'b0};
        vecs[7]  = '{4'b0010, 4'b1000, 1'b1};
        vecs[8]  = '{4'b0010, 4'b1001, 1'b0};
        vecs[9]  = '{4'b0110, 4'b1000, 1'b0};
        vecs[10] = '{4'b0110, 4'b1001, 1'b1};
        vecs[11] = '{4'b1000, 4'b0100, 1'b1};
        vecs[12] = '{4'b1000, 4'b0101, 1'b0};
        vecs[13] = '{4'b1000, 4'b1011, 1'b1};
        vecs[14] = '{4'b1000, 4'b1010, 1'b0};
        vecs[15] = '{4'b0001, 4'b0110, 1'b1};
        vecs[16] = '{4'b0001, 4'b0111, 1'b0};
        vecs[17] = '{4'b0000, 4'b1110, 1'b1};
        vecs[18] = '{4'b0000, 4'b1111, 1'b1};
        vecs[19] = '{4'b0000, 4'b0001, 1'b1};
        vecs[20] = '{4'b0000, 4'b0000, 1'b0};
        vecs[21] = '{4'b1100, 4'b1100, 1'b0};
        vecs[22] = '{4'b1100, 4'b1101, 1'b1};
        vecs[23] = '{4'b0001, 4'b1011, 1'b1};

        // Reset for two cycles.
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_flags_q", {4'h0, bus.flags_q}, 8'h00);
        chk("rst_itstate", bus.itstate, 8'h00);
        chk("rst_it_active", {7'h0, bus.it_active}, 8'h00);
        chk("rst_it_err", {7'h0, bus.it_err}, 8'h00);
        chk("rst_exec_en", {7'h0, bus.exec_en}, 8'h00);

        // Condition table.
        for (int i = 0; i < 24; i++) begin
            load_flags(vecs[i].f);
            bus.cond_in = vecs[i].c;
            #1;
            chk($sformatf("flags_load_%0d", i), {4'h0, bus.flags_q}, {4'h0, vecs[i].f});
            chk($sformatf("cond_%0d", i), {7'h0, bus.cond_pass}, {7'h0, vecs[i].exp});
        end

        // Idle cycle with flags_we: no instruction, no write.
        load_flags(4'b0100);
        bus.flags_we = 1'b1;
        bus.flags_in = 4'b1011;
        #1;
        chk("idle_exec_en", {7'h0, bus.exec_en}, 8'h00);
        tick();
        bus.flags_we = 1'b0;
        chk("idle_flags_hold", {4'h0, bus.flags_q}, 8'h04);

        // Issuing outside an IT block executes.
        bus.instr_valid = 1'b1;
        #1;
        chk("plain_exec_en", {7'h0, bus.exec_en}, 8'h01);
        idle();

`ifdef COND_UNIT_IT_EN
        // ITT EQ with Z=1; the IT slot's own flag write is blocked.
        issue_it(4'b0000, 4'b0100);
        bus.flags_we = 1'b1;
        bus.flags_in = 4'b0000;
        #1;
        chk("itt_it_exec_en", {7'h0, bus.exec_en}, 8'h00);
        tick();
        idle();
        chk("itt_itstate0", bus.itstate, 8'h04);
        chk("itt_flags_kept", {4'h0, bus.flags_q}, 8'h04);
        chk("itt_active0", {7'h0, bus.it_active}, 8'h01);
        bus.instr_valid = 1'b1;
        #1;
        chk("itt_exec1", {7'h0, bus.exec_en}, 8'h01);
        tick();
        chk("itt_itstate1", bus.itstate, 8'h08);
        chk("itt_exec2", {7'h0, bus.exec_en}, 8'h01);
        tick();
        chk("itt_itstate2", bus.itstate, 8'h00);
        chk("itt_active2", {7'h0, bus.it_active}, 8'h00);
        idle();

        // ITE EQ with Z=0: first skipped (flags kept), second executes.
        load_flags(4'b0000);
        issue_it(4'b0000, 4'b1100);
        tick();
        idle();
        chk("ite_itstate0", bus.itstate, 8'h0c);
        bus.instr_valid = 1'b1;
        bus.flags_we    = 1'b1;
        bus.flags_in    = 4'b1111;
        #1;
        chk("ite_exec1", {7'h0, bus.exec_en}, 8'h00);
        tick();
        bus.flags_we = 1'b0;
        chk("ite_flags_kept", {4'h0, bus.flags_q}, 8'h00);
        chk("ite_itstate1", bus.itstate, 8'h18);
        chk("ite_exec2", {7'h0, bus.exec_en}, 8'h01);
        tick();
        chk("ite_itstate2", bus.itstate, 8'h00);
        idle();

        // IT NE, mask 1000: idle cycles hold ITSTATE, one instruction covered.
        issue_it(4'b0001, 4'b1000);
        tick();
        idle();
        tick();
        tick();
        tick();
        chk("hold_itstate", bus.itstate, 8'h18);
        bus.instr_valid = 1'b1;
        #1;
        chk("hold_exec", {7'h0, bus.exec_en}, 8'h01);
        tick();
        chk("single_done", {7'h0, bus.it_active}, 8'h00);
        idle();

        // Empty mask: one-cycle error pulse, ITSTATE untouched.
        issue_it(4'b0000, 4'b0000);
        tick();
        idle();
        chk("mask0_err", {7'h0, bus.it_err}, 8'h01);
        chk("mask0_itstate", bus.itstate, 8'h00);
        tick();
        chk("mask0_err_clear", {7'h0, bus.it_err}, 8'h00);

        // firstcond 1111 is illegal.
        issue_it(4'b1111, 4'b1000);
        tick();
        idle();
        chk("fc15_err", {7'h0, bus.it_err}, 8'h01);
        chk("fc15_itstate", bus.itstate, 8'h00);

        // Nested IT inside a block: error, no advance.
        issue_it(4'b0000, 4'b0010);
        tick();
        chk("nest_itstate0", bus.itstate, 8'h02);
        issue_it(4'b0001, 4'b1000);
        tick();
        idle();
        chk("nest_err", {7'h0, bus.it_err}, 8'h01);
        chk("nest_itstate", bus.itstate, 8'h02);

        // Reset mid-block, with a competing flag write.
        rst             = 1'b1;
        bus.instr_valid = 1'b1;
        bus.flags_we    = 1'b1;
        bus.flags_in    = 4'b1111;
        tick();
        rst = 1'b0;
        idle();
        chk("midrst_itstate", bus.itstate, 8'h00);
        chk("midrst_active", {7'h0, bus.it_active}, 8'h00);
        chk("midrst_flags", {4'h0, bus.flags_q}, 8'h00);
        chk("midrst_err", {7'h0, bus.it_err}, 8'h00);
`else
        // Without IT support it_start is ignored: the slot executes and writes flags.
        issue_it(4'b0000, 4'b0100);
        bus.flags_we = 1'b1;
        bus.flags_in = 4'b1010;
        #1;
        chk("noit_exec_en", {7'h0, bus.exec_en}, 8'h01);
        tick();
        idle();
        chk("noit_itstate", bus.itstate, 8'h00);
        chk("noit_active", {7'h0, bus.it_active}, 8'h00);
        chk("noit_flags", {4'h0, bus.flags_q}, 8'h0a);
        issue_it(4'b0000, 4'b0000);
        tick();
        idle();
        chk("noit_err", {7'h0, bus.it_err}, 8'h00);
        chk("noit_itstate2", bus.itstate, 8'h00);

        // Reset overrides a same-cycle flag write.
        rst             = 1'b1;
        bus.instr_valid = 1'b1;
        bus.flags_we    = 1'b1;
        bus.flags_in    = 4'b1111;
        tick();
        rst = 1'b0;
        idle();
        chk("noit_rst_flags", {4'h0, bus.flags_q}, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
